mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Round-robin arbitration is selected at build time with MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int MEM_ARB_NUM_REQ = 3;
    localparam int MEM_ARB_ADDR_W  = 9;
    localparam int MEM_ARB_DATA_W  = 32;

    // Requester slots as wired at the CPU boundary.
    localparam int REQ_DATA   = 0;
    localparam int REQ_FETCH  = 1;
    localparam int REQ_LOADER = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Width of a requester index; a single-requester build still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational one-hot picker: first set request found scanning upward
// from i_base (wrapping), so i_base=0 gives lowest-index priority.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter  int N  = MEM_ARB_NUM_REQ,
    localparam int PW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_base,
    output logic [N-1:0]  o_gnt
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_base) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one synchronous single-port RAM among NUM_REQ requesters.
// Registered one-hot grant with requester lock; MEM_ARB_RR_EN enables round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = MEM_ARB_NUM_REQ,
    parameter int ADDR_WIDTH = MEM_ARB_ADDR_W,
    parameter int DATA_WIDTH = MEM_ARB_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    localparam int OW = idx_w(NUM_REQ);

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [NUM_REQ-1:0] w_acc;
    logic [NUM_REQ-1:0] w_pick;
    logic [OW-1:0]      w_owner;
    logic [OW-1:0]      w_base;
    logic               w_any;
    logic               w_hold;

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) w_owner = OW'(i);
        end
    end

    // Grant only turns into a RAM access while the owner still requests.
    assign w_acc  = r_gnt & req;
    assign w_any  = |req;
    assign w_hold = |(w_acc & lock);

`ifdef MEM_ARB_RR_EN
    logic [OW-1:0] r_ptr;
    logic [OW-1:0] w_next_ptr;
    logic          w_ptr_upd;

    assign w_next_ptr = (w_owner == OW'(NUM_REQ - 1)) ? '0 : w_owner + OW'(1);
    assign w_ptr_upd  = (|w_acc) && (r_state != ST_LOCKED);
    // The search for the next grant already starts past this cycle's winner.
    assign w_base     = w_ptr_upd ? w_next_ptr : r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_ptr_upd) begin
            r_ptr <= w_next_ptr;
        end
    end
`else
    assign w_base = '0;
`endif

    arb_pick #(.N(NUM_REQ)) u_pick (
        .i_req  (req),
        .i_base (w_base),
        .o_gnt  (w_pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_acc & ~we;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_pick;
                    end
                end
                ST_GRANT, ST_LOCKED: begin
                    if (w_hold) begin
                        r_state <= ST_LOCKED;
                    end else if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_pick;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (|w_acc) begin
            ram_en    = 1'b1;
            ram_we    = we[w_owner];
            ram_addr  = addr[w_owner*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata = wdata[w_owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = ram_rdata;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_gnt));
    a_rv_onehot:  assert property (@(posedge clk) disable iff (!reset) $onehot0(r_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            ram_en, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic            ram_init;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 4) ? 32'h2008FFFF : (32'hC0DE0000 | a);
    endfunction

    // RAM fixture: synchronous single port, read data one cycle after access.
    logic [DW-1:0] mem [512];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 512; a++) mem[a] <= init_val(a);
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit r, input bit l, input bit w,
                         input int a, input logic [DW-1:0] d);
        req[i]             = r;
        lock[i]            = l;
        we[i]              = w;
        addr[i*AW +: AW]   = AW'(a);
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            req = '0; lock = '0; we = '0;
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] gnt_fx;
        logic [N-1:0] gnt_rr;
        logic         en;
    } vec_t;

    // Reference model state (transaction level).
    int            m_owner, m_ptr, rv_own;
    bit            m_locked;
    logic [DW-1:0] rv_dat;
    logic [DW-1:0] shadow [512];
    logic [N-1:0]  acc_prev;

    function automatic int choose(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = RR ? (ptr + k) % N : k;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic new_txn(input int i);
        drive(i, 1'b1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 31), $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        bit   acc;
        int   a;

        // cycle:      req     lock    gnt fixed gnt rr  ram_en
        tbl[0]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[2]  = '{3'b111, 3'b000, 3'b001, 3'b001, 1'b1};
        tbl[3]  = '{3'b111, 3'b000, 3'b001, 3'b010, 1'b1};
        tbl[4]  = '{3'b111, 3'b000, 3'b001, 3'b100, 1'b1};
        tbl[5]  = '{3'b111, 3'b000, 3'b001, 3'b001, 1'b1};
        tbl[6]  = '{3'b000, 3'b000, 3'b001, 3'b010, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[8]  = '{3'b000, 3'b111, 3'b000, 3'b000, 1'b0};
        tbl[9]  = '{3'b010, 3'b101, 3'b000, 3'b000, 1'b0};
        tbl[10] = '{3'b000, 3'b000, 3'b010, 3'b010, 1'b0};
        tbl[11] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0};

        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        reset = 1'b0; ram_init = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ram_en", ram_en, 0);
        ram_init = 1'b0;
        reset    = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_gnt", gnt, 0);
            chk("idle_ram_en", ram_en, 0);
        end

        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(i * 16);
        for (int r = 0; r < 12; r++) begin
            step();
            req  = tbl[r].req;
            lock = tbl[r].lock;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", r), gnt, RR ? tbl[r].gnt_rr : tbl[r].gnt_fx);
            chk($sformatf("vec%0d_en", r), ram_en, tbl[r].en);
        end
        idle(3);

        // Single read by fetch port.
        step(); drive(REQ_FETCH, 1, 0, 0, 4, 0);
        @(negedge clk); chk("rd_t0_gnt", gnt, 0);
        step();
        @(negedge clk); chk("rd_gnt", gnt, 3'b010);
        chk("rd_en", ram_en, 1); chk("rd_addr", ram_addr, 9'h004);
        step(); req = '0;
        @(negedge clk); chk("rd_rvalid", rvalid, 3'b010);
        chk("rd_rdata", rdata, 32'h2008FFFF);
        idle(3);

        // Write then read back by data port.
        step(); drive(REQ_DATA, 1, 0, 1, 9'h1F0, 32'h00FF0000);
        @(negedge clk); chk("wr_t0_gnt", gnt, 0);
        step();
        @(negedge clk); chk("wr_gnt", gnt, 3'b001); chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 9'h1F0); chk("wr_wdata", ram_wdata, 32'h00FF0000);
        chk("wr_rvalid", rvalid, 0);
        step(); we[REQ_DATA] = 1'b0;
        @(negedge clk); chk("wrrd_gnt", gnt, 3'b001); chk("wrrd_we", ram_we, 0);
        chk("wr_norv", rvalid, 0);
        step(); req = '0;
        @(negedge clk); chk("wrrd_rvalid", rvalid, 3'b001);
        chk("wrrd_rdata", rdata, 32'h00FF0000);
        idle(3);

        // Locked 8-word loader burst with the data port waiting.
        step(); drive(REQ_LOADER, 1, 1, 1, 0, 32'hB0000000);
        @(negedge clk); chk("lk_pre_gnt", gnt, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (k > 0) begin
                addr[REQ_LOADER*AW +: AW]  = AW'(k);
                wdata[REQ_LOADER*DW +: DW] = 32'hB0000000 + k;
            end
            if (k == 1) drive(REQ_DATA, 1, 0, 0, 3, 0);
            if (k == 7) lock[REQ_LOADER] = 1'b0;
            @(negedge clk);
            chk($sformatf("lk%0d_gnt", k), gnt, 3'b100);
            chk($sformatf("lk%0d_addr", k), ram_addr, AW'(k));
        end
        step(); req[REQ_LOADER] = 1'b0;
        @(negedge clk); chk("lk_after_gnt", gnt, 3'b001);
        chk("lk_after_en", ram_en, 1); chk("lk_after_addr", ram_addr, 9'h003);
        step(); req = '0;
        @(negedge clk); chk("lk_rvalid", rvalid, 3'b001);
        chk("lk_rdata", rdata, 32'hB0000003);
        idle(3);

        // Reset lands while a read's rvalid is pending.
        step(); drive(REQ_FETCH, 1, 0, 0, 4, 0);
        step();
        @(negedge clk); chk("rr_gnt", gnt, 3'b010);
        @(posedge clk); #1;
        reset = 1'b0; req = '0;
        #1;
        chk("rstmid_gnt", gnt, 0);
        chk("rstmid_rvalid", rvalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("rstmid_post_rv", rvalid, 0);
        end

        // Randomized traffic vs. reference model.
        reset = 1'b0; ram_init = 1'b1; req = '0; lock = '0; we = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; ram_init = 1'b0;
        for (int i = 0; i < 512; i++) shadow[i] = init_val(i);
        m_owner = -1; m_ptr = 0; m_locked = 1'b0; rv_own = -1; rv_dat = '0; acc_prev = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (acc_prev[i]) begin
                        if ($urandom_range(0, 3) != 0) new_txn(i);
                        else begin req[i] = 1'b0; lock[i] = ($urandom_range(0, 4) == 0); end
                    end
                end else if ($urandom_range(0, 2) == 0) new_txn(i);
                else lock[i] = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            acc = (m_owner >= 0) && req[m_owner];
            chk("rnd_gnt", gnt, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
            chk("rnd_en", ram_en, acc);
            if (acc) begin
                a = int'(addr[m_owner*AW +: AW]);
                chk("rnd_we", ram_we, we[m_owner]);
                chk("rnd_addr", ram_addr, a);
                if (we[m_owner]) chk("rnd_wdata", ram_wdata, wdata[m_owner*DW +: DW]);
            end
            chk("rnd_rvalid", rvalid, (rv_own >= 0) ? (64'd1 << rv_own) : 64'd0);
            if (rv_own >= 0) chk("rnd_rdata", rdata, rv_dat);

            rv_own   = -1;
            acc_prev = '0;
            if (acc) begin
                acc_prev[m_owner] = 1'b1;
                if (we[m_owner]) shadow[a] = wdata[m_owner*DW +: DW];
                else begin rv_own = m_owner; rv_dat = shadow[a]; end
                if (!m_locked) m_ptr = (m_owner + 1) % N;
            end
            if (acc && lock[m_owner]) m_locked = 1'b1;
            else begin
                m_locked = 1'b0;
                m_owner  = choose(req, m_ptr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
